// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing for the FIFO controller: pointer/level widths and skid depth.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package fifo_ctrl_pkg;

    // Output skid buffer depth and the width of its occupancy counter (0..2).
    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = 2;

    // Read/write pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Level covers the RAM depth plus the skid entries: 2**ADDR+2 fits in ADDR+2 bits.
    function automatic int lvl_width(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry output skid buffer that captures RAM read data and presents the FIFO head.
// Latency: a word pushed at an edge is visible on o_dat/o_vld in the following cycle.
// Backpressure: o_vld/i_pop_rdy handshake; upstream must never push into a full buffer.
//   clK, rst_N        : clock, async active-low reset
//   i_push/i_push_dat : capture i_push_dat into the tail at the next edge
//   i_pop_rdy         : consumer ready; pop happens when o_vld is also high
//   o_vld/o_dat/o_occ : head valid, head word, entries held (0..2)
module fifo_skid2
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA = 16
) (
    input  logic             clK,
    input  logic             rst_N,
    input  logic             i_push,
    input  logic [DATA-1:0]  i_push_dat,
    input  logic             i_pop_rdy,
    output logic             o_vld,
    output logic [DATA-1:0]  o_dat,
    output logic [OCC_W-1:0] o_occ
);

    logic [DATA-1:0]  r_head;
    logic [DATA-1:0]  r_tail;
    logic [OCC_W-1:0] r_occ;
    logic             w_pop;

    assign o_vld = (r_occ != '0);
    assign o_dat = r_head;
    assign o_occ = r_occ;
    assign w_pop = o_vld && i_pop_rdy;

    // A same-cycle pop retires the head before the new word lands, so the
    // incoming word goes to whichever slot becomes the tail afterwards.
    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == '0) r_head <= i_push_dat;
                    else             r_tail <= i_push_dat;
                    r_occ <= r_occ + OCC_W'(1);
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - OCC_W'(1);
                end
                2'b11: begin
                    if (r_occ == OCC_W'(1)) begin
                        r_head <= i_push_dat;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    // The controller's issue rule must never overfill the buffer.
    a_no_overflow: assert property (@(posedge clK) disable iff (!rst_N)
        !(i_push && !w_pop && (r_occ == OCC_W'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving a dual-port RAM (A = write, B = 1-cycle registered read).
// Latency: push into an empty FIFO appears at rd_VALID three cycles later; pop sustains 1 word/cycle.
// Backpressure: wr_READY drops when the RAM is full; rd_VALID/rd_READY handshake on the output.
//   clK, rst_N                          : clock, async active-low reset
//   wr_VALID/wr_READY/wr_DATA           : push interface
//   rd_VALID/rd_READY/rd_DATA           : pop interface (head word)
//   fifo_FULL/fifo_EMPTY/fifo_LEVEL     : status, level counts RAM + in-flight + skid words
//   ram_a_* / ram_b_*                   : RAM port A write, port B read
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA = 16,
    parameter int ADDR = 5
) (
    input  logic                       clK,
    input  logic                       rst_N,
    input  logic                       wr_VALID,
    output logic                       wr_READY,
    input  logic [DATA-1:0]            wr_DATA,
    output logic                       rd_VALID,
    input  logic                       rd_READY,
    output logic [DATA-1:0]            rd_DATA,
    output logic                       fifo_FULL,
    output logic                       fifo_EMPTY,
    output logic [lvl_width(ADDR)-1:0] fifo_LEVEL,
    output logic                       ram_a_WR,
    output logic [ADDR-1:0]            ram_a_ADDR,
    output logic [DATA-1:0]            ram_a_data_IN,
    output logic                       ram_b_WR,
    output logic [ADDR-1:0]            ram_b_ADDR,
    output logic [DATA-1:0]            ram_b_data_IN,
    input  logic [DATA-1:0]            ram_b_data_OUT
);

    localparam int PTR_W = ptr_width(ADDR);
    localparam int LVL_W = lvl_width(ADDR);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_pend;     // RAM read issued last cycle, data arrives this cycle
    logic             r_live;     // holds wr_READY low until the first edge after reset

    logic             w_ram_empty;
    logic             w_ram_full;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic             w_rd_vld;
    logic [OCC_W-1:0] w_occ;
    logic [OCC_W:0]   w_after;    // skid occupancy after this edge, before any new issue lands
    logic [PTR_W-1:0] w_ram_cnt;

    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
    assign w_ram_full  = (r_wr_ptr[ADDR-1:0] == r_rd_ptr[ADDR-1:0]) &&
                         (r_wr_ptr[ADDR] != r_rd_ptr[ADDR]);

    assign wr_READY = r_live && !w_ram_full;
    assign w_push   = wr_VALID && wr_READY;
    assign w_pop    = w_rd_vld && rd_READY;

    // Only issue a read if the skid will have a free slot when the data returns.
    // A pop only happens with occ >= 1, so this never underflows.
    assign w_after = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_pend} - {{OCC_W{1'b0}}, w_pop};
    assign w_issue = !w_ram_empty && (w_after <= (OCC_W+1)'(1));

    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_pend   <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_pend <= w_issue;
        end
    end

    // Port A: combinational write from the push handshake.
    assign ram_a_WR      = w_push;
    assign ram_a_ADDR    = r_wr_ptr[ADDR-1:0];
    assign ram_a_data_IN = wr_DATA;

    // Port B: read-only; address idles at the read pointer.
    assign ram_b_WR      = 1'b0;
    assign ram_b_ADDR    = r_rd_ptr[ADDR-1:0];
    assign ram_b_data_IN = '0;

    fifo_skid2 #(
        .DATA (DATA)
    ) u_skid (
        .clK        (clK),
        .rst_N      (rst_N),
        .i_push     (r_pend),
        .i_push_dat (ram_b_data_OUT),
        .i_pop_rdy  (rd_READY),
        .o_vld      (w_rd_vld),
        .o_dat      (rd_DATA),
        .o_occ      (w_occ)
    );

    assign rd_VALID   = w_rd_vld;
    assign fifo_EMPTY = !w_rd_vld;
    assign fifo_FULL  = !wr_READY;

    // Pointer difference is taken at pointer width before widening, so the wrap is modular.
    assign w_ram_cnt  = r_wr_ptr - r_rd_ptr;
    assign fifo_LEVEL = {1'b0, w_ram_cnt}
                      + {{(LVL_W-1){1'b0}}, r_pend}
                      + {{(LVL_W-OCC_W){1'b0}}, w_occ};

endmodule
